// File: rtl/preempt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : preempt_pkg
// Description : Shared types for the preemption controller: FSM state
//               encoding and flagUpdateData register-load codes.
// Revision    : 1.0 - initial release
// ============================================================================
package preempt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    IRQ    = 2'd2,
    SWITCH = 2'd3
  } state_e;

  localparam logic [2:0] UPD_NONE    = 3'd0;
  localparam logic [2:0] UPD_QUANTUM = 3'd1;
  localparam logic [2:0] UPD_CS_ADDR = 3'd2;
  localparam logic [2:0] UPD_PC_PROC = 3'd3;

endpackage : preempt_pkg
`default_nettype wire

// File: rtl/quantum_counter.sv
`default_nettype none
// ============================================================================
// Module      : quantum_counter
// Description : Retired-instruction down-counter for one scheduling quantum.
//               load_i has priority over dec_i. A count of zero disables
//               preemption (never decrements, never expires).
// Ports       : clock, reset (async, active-low)
//               load_i / load_val_i - reload the count
//               dec_i               - one retired instruction
//               count_o             - current count
//               expire_o            - this decrement ends the quantum
// Revision    : 1.0 - initial release
// ============================================================================
module quantum_counter #(
  parameter int QUANTUM_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [QUANTUM_W-1:0] load_val_i,
  input  logic                 dec_i,
  output logic [QUANTUM_W-1:0] count_o,
  output logic                 expire_o
);

  localparam logic [QUANTUM_W-1:0] C_ONE = QUANTUM_W'(1);

  logic [QUANTUM_W-1:0] count_q;
  logic [QUANTUM_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      // Floor at zero: the expiring decrement lands on 0, never wraps.
      count_d = count_q - C_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = dec_i && !load_i && (count_q == C_ONE);

endmodule : quantum_counter
`default_nettype wire

// File: rtl/preemption_controller.sv
`default_nettype none
// ============================================================================
// Module      : preemption_controller
// Description : Initiator side of the preemption handshake. Counts retired
//               instructions while armed; on quantum expiry it captures the
//               running PC, holds `interruption` for SAVE_CYCLES cycles, then
//               strobes flagLoadPC for one cycle to jump to csAddr.
// Ports       : clock, reset (async, active-low)
//               flagMP, flagUpdateData, dataIn - control-unit writes
//               advance, pcCurrent             - retirement / running PC
//               interruption, flagLoadPC, pcTarget, pcProcess, armed
//               irqCount (only with PREEMPT_IRQ_COUNT_EN defined)
// Option      : PREEMPT_IRQ_COUNT_EN - adds saturating 8-bit switch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module preemption_controller
  import preempt_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int QUANTUM_W   = 16,
  parameter int SAVE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flagMP,
  input  logic [2:0]        flagUpdateData,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              advance,
  input  logic [ADDR_W-1:0] pcCurrent,
  output logic              interruption,
  output logic              flagLoadPC,
  output logic [ADDR_W-1:0] pcTarget,
  output logic [ADDR_W-1:0] pcProcess,
  output logic              armed
`ifdef PREEMPT_IRQ_COUNT_EN
  ,
  output logic [7:0]        irqCount
`endif
);

  localparam int                HOLD_W    = (SAVE_CYCLES > 1) ? $clog2(SAVE_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SAVE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [QUANTUM_W-1:0]  quantum_q, quantum_d;
  logic [ADDR_W-1:0]     cs_addr_q, cs_addr_d;
  logic [ADDR_W-1:0]     pc_proc_q, pc_proc_d;

  logic                  w_load;
  logic [QUANTUM_W-1:0]  w_load_val;
  logic                  w_dec;
  logic                  w_expire;
  logic [QUANTUM_W-1:0]  w_count;

  // Upper dataIn bits are discarded by the truncating loads.
  logic unused_data;
  assign unused_data = ^dataIn;

  // Arming reloads the count; a quantum written in the same cycle bypasses
  // the register so the new value takes effect immediately.
  assign w_load     = flagMP && ((state_q == IDLE) || (state_q == RUN));
  assign w_load_val = (flagUpdateData == UPD_QUANTUM) ? dataIn[QUANTUM_W-1:0] : quantum_q;
  assign w_dec      = advance && (state_q == RUN);

  quantum_counter #(
    .QUANTUM_W (QUANTUM_W)
  ) u_quantum_counter (
    .clock      (clock),
    .reset      (reset),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .dec_i      (w_dec),
    .count_o    (w_count),
    .expire_o   (w_expire)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (flagMP) state_d = RUN;
      end
      RUN: begin
        if (w_expire) begin
          state_d = IRQ;
          hold_d  = '0;
        end
      end
      IRQ: begin
        if (hold_q == HOLD_LAST) begin
          state_d = SWITCH;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      SWITCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // --------------------------------------------------------------------------
  // Context registers
  // --------------------------------------------------------------------------
  always_comb begin
    quantum_d = quantum_q;
    cs_addr_d = cs_addr_q;
    pc_proc_d = pc_proc_q;
    if (flagUpdateData == UPD_QUANTUM) quantum_d = dataIn[QUANTUM_W-1:0];
    if (flagUpdateData == UPD_CS_ADDR) cs_addr_d = dataIn[ADDR_W-1:0];
    // Capture of the running PC wins over a software write; software writes
    // are blocked while the save window is open.
    if (w_expire) begin
      pc_proc_d = pcCurrent;
    end else if ((flagUpdateData == UPD_PC_PROC) && (state_q != IRQ)) begin
      pc_proc_d = dataIn[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      quantum_q <= '0;
      cs_addr_q <= '0;
      pc_proc_q <= '0;
    end else begin
      quantum_q <= quantum_d;
      cs_addr_q <= cs_addr_d;
      pc_proc_q <= pc_proc_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them
  // without waiting for a clock edge.
  assign interruption = (state_q == IRQ) || (state_q == SWITCH);
  assign flagLoadPC   = (state_q == SWITCH);
  assign armed        = (state_q == RUN);
  assign pcTarget     = cs_addr_q;
  assign pcProcess    = pc_proc_q;

`ifdef PREEMPT_IRQ_COUNT_EN
  logic [7:0] irq_cnt_q, irq_cnt_d;

  always_comb begin
    irq_cnt_d = irq_cnt_q;
    if ((state_q == SWITCH) && (irq_cnt_q != 8'hFF)) irq_cnt_d = irq_cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_cnt_q <= '0;
    end else begin
      irq_cnt_q <= irq_cnt_d;
    end
  end

  assign irqCount = irq_cnt_q;
`endif

endmodule : preemption_controller
`default_nettype wire

// File: doc/preemption_controller.md
Name: preemption_controller

Overview:
- Source of the `interruption` input that the processor's control unit consumes. It is the initiator side of the preemption handshake.
- Holds the multiprogramming context:
  - quantum length
  - context-switch (kernel) address
  - per-process saved PC
- Counts retired instructions while multiprogramming is armed. On quantum expiry it freezes the core, captures the running PC and forces a jump to the context-switch address.
- Sits beside the PC unit; it is written through the control unit's flagMP / flagUpdateData decode.

Parameters:
- DATA_W, 32, width of the register-file data bus (dataIn).
- ADDR_W, 10, instruction-memory address width.
- QUANTUM_W, 16, quantum counter width.
- SAVE_CYCLES, 2, cycles `interruption` is held before the PC redirect (min 1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flagMP  in  1  arm multiprogramming; sampled every cycle.
- flagUpdateData  in  3  1 = load quantum, 2 = load CS address, 3 = load process PC, others = none.
- dataIn  in  DATA_W  register-file operand that supplies the loaded values.
- advance  in  1  high for one cycle per retired instruction (control unit flagPC != 0).
- pcCurrent  in  ADDR_W  PC of the running instruction.
- interruption  out  1  freezes the control unit (all flags zero).
- flagLoadPC  out  1  one-cycle strobe: PC <= pcTarget.
- pcTarget  out  ADDR_W  redirect address; equals csAddr.
- pcProcess  out  ADDR_W  saved/resume PC, read by GET_PC_PROCESS.
- armed  out  1  high in RUN.

Behaviour:
- Reset (reset = 0, async) forces:
  - state = IDLE
  - interruption = 0, flagLoadPC = 0, armed = 0
  - quantumReg = 0, csAddr = 0, pcProcess = 0, count = 0
  - all outputs take these values immediately.
  - Reset asserted mid-IRQ/SWITCH aborts the sequence with no redirect.
- Register loads (any state, rising clock edge):
  - flagUpdateData == 1: quantumReg <= dataIn[QUANTUM_W-1:0].
  - flagUpdateData == 2: csAddr <= dataIn[ADDR_W-1:0].
  - flagUpdateData == 3: pcProcess <= dataIn[ADDR_W-1:0].
  - Other codes have no effect.
- pcTarget is a continuous copy of csAddr.
- FSM states: IDLE, RUN, IRQ, SWITCH.
- IDLE:
  - flagMP = 1 -> RUN with count <= quantumReg.
  - If flagUpdateData == 1 in the same cycle, count takes the new dataIn value (bypass).
- RUN (armed = 1):
  - flagMP = 1 re-arms (count reload, same bypass rule).
  - advance = 1 and count > 1: count decrements.
  - advance = 1 and count == 1: go to IRQ; pcProcess <= pcCurrent. This capture wins over a simultaneous flagUpdateData == 3.
  - count == 0 (quantum 0): never preempts; stays in RUN.
  - advance = 0: count holds.
- IRQ:
  - interruption = 1 for exactly SAVE_CYCLES cycles, then SWITCH.
  - flagMP, advance and the flagUpdateData == 3 load are ignored.
  - flagUpdateData == 1 and 2 still load.
- SWITCH:
  - One cycle with interruption = 1 and flagLoadPC = 1 (pcTarget = csAddr).
  - Then IDLE: interruption = 0, armed = 0.
  - The kernel must re-arm via flagMP.
- Latency:
  - Expiring advance edge -> interruption high next cycle.
  - flagLoadPC asserted SAVE_CYCLES + 1 cycles after that advance.
  - flagLoadPC is never asserted outside SWITCH.
- Width rules:
  - Loads truncate dataIn to the lower bits.
  - count never wraps below 0.

Optional Feature:
- Macro: PREEMPT_IRQ_COUNT_EN.
- Defined:
  - Adds output irqCount [7:0].
  - Increments once per SWITCH cycle and saturates at 255.
  - Async-reset to 0.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Package preempt_pkg holds:
  - state enum {IDLE, RUN, IRQ, SWITCH}
  - UPD_NONE = 0, UPD_QUANTUM = 1, UPD_CS_ADDR = 2, UPD_PC_PROC = 3
- Sub-module quantum_counter:
  - load, decrement, expire detect, zero-means-disabled
  - parameter QUANTUM_W
- FSM, registers and the SAVE_CYCLES hold counter live in the top module.

Test Plan:
- Reset test: hold reset low for 3 cycles, then release -> all outputs 0, state IDLE, pcTarget = 0.
- Normal expiry:
  - Stimulus: load quantum 3, csAddr 0x040, flagMP pulse; three advance pulses with pcCurrent 0x010/0x011/0x012.
  - Response: interruption high the cycle after the 3rd advance, for 2 cycles. Then flagLoadPC = 1 with pcTarget 0x040 for one cycle. pcProcess = 0x012. Back to IDLE, armed = 0.
- Quantum 0: arm, then 100 advance pulses -> interruption stays 0, armed stays 1.
- Simultaneous load and capture: flagUpdateData = 3 with dataIn 0x3FF on the expiring advance -> pcProcess = pcCurrent, not 0x3FF.
- Async reset during IRQ: assert reset in the 1st IRQ cycle -> interruption drops immediately, no flagLoadPC.
- PREEMPT_IRQ_COUNT_EN defined: run 257 quantum-1 preemptions -> irqCount = 255.
